// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of PC/instruction pairs between the
// I-memory response port and the IF/ID register. Option: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   FLUSH,
   input  logic                   IN_VALID,
   output logic                   IN_READY,
   input  logic [31:0]            IN_PC,
   input  logic [WIDTH-1:0]       IN_IR,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic [31:0]            OUT_PC,
   output logic [WIDTH-1:0]       OUT_IR,
   output logic [$clog2(DEPTH):0] COUNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("fetch_queue: DEPTH must be a power of two and at least 2");
   end

   logic [31:0]      mem_pc [DEPTH];
   logic [WIDTH-1:0] mem_ir [DEPTH];

   logic [AW-1:0] rp_q, wp_q;
   logic [CW-1:0] count_q;

   logic empty;
   logic bypass;
   logic out_valid;
   logic push;
   logic pop_mem;

   assign empty    = (count_q == '0);
   assign IN_READY = (count_q != CW'(DEPTH));
   assign COUNT    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
   // An empty queue forwards the incoming entry straight to the head.
   assign bypass = empty & IN_VALID;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = (~empty | bypass) & ~FLUSH;
   assign OUT_VALID = out_valid;

   // A bypassed entry taken by the consumer in the same cycle never enters storage.
   assign push    = IN_VALID & IN_READY & ~FLUSH & ~(bypass & OUT_READY);
   assign pop_mem = out_valid & OUT_READY & ~bypass;

   // NOTE: every output of this block gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      OUT_PC = '0;
      OUT_IR = NOP;
      if (out_valid) begin
         if (bypass) begin
            OUT_PC = IN_PC;
            OUT_IR = IN_IR;
         end else begin
            OUT_PC = mem_pc[rp_q];
            OUT_IR = mem_ir[rp_q];
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rp_q    <= '0;
         wp_q    <= '0;
         count_q <= '0;
      end else if (FLUSH) begin
         rp_q    <= '0;
         wp_q    <= '0;
         count_q <= '0;
      end else begin
         if (push)    wp_q <= wp_q + AW'(1);
         if (pop_mem) rp_q <= rp_q + AW'(1);
         unique case ({push, pop_mem})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage has no reset; entries are only readable once count covers
   // them, so clearing the array would cost area without changing behaviour.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_pc[wp_q] <= IN_PC;
         mem_ir[wp_q] <= IN_IR;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue; a queue-level model predicts
// acceptance and the monitor pops expected entries on every head handshake.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [WIDTH-1:0] NOP = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_pc;
   logic [WIDTH-1:0] in_ir;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [WIDTH-1:0] out_ir;
   logic [CW-1:0]    count;

   fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .CLK(clk), .RST_N(rst_n), .FLUSH(flush),
      .IN_VALID(in_valid), .IN_READY(in_ready), .IN_PC(in_pc), .IN_IR(in_ir),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_PC(out_pc), .OUT_IR(out_ir),
      .COUNT(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      pc;
      logic [WIDTH-1:0] ir;
   } ent_t;

   ent_t sb[$];
   int   m_cnt;    // occupancy the DUT holds during the current cycle
   int   m_next;   // occupancy expected after the coming edge
   bit   exp_ov;
   bit   mon_en;
   int   total;
   int   bad;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the model decides acceptance from queue occupancy.
   task automatic step(input bit v, input logic [31:0] pc, input bit fl, input bit ordy,
                       output bit acc);
      bit byp;
      @(posedge clk);
      #1;
      m_cnt     = m_next;
      in_valid  = v;
      in_pc     = pc;
      in_ir     = $urandom;
      flush     = fl;
      out_ready = ordy;
      acc       = 1'b0;
      byp       = BYP && m_cnt == 0 && v;
      if (fl) begin
         sb.delete();
         exp_ov = 1'b0;
         m_next = 0;
      end else begin
         acc    = v && m_cnt < DEPTH;
         exp_ov = m_cnt > 0 || byp;
         if (acc) sb.push_back('{pc: pc, ir: in_ir});
         m_next = m_cnt + ((acc && !(byp && ordy)) ? 1 : 0)
                        - ((exp_ov && ordy && !byp) ? 1 : 0);
      end
   endtask

   task automatic idle(input bit ordy);
      bit a;
      step(1'b0, 32'h0, 1'b0, ordy, a);
   endtask

   // Offer one PC until the queue takes it, bounded so a stuck IN_READY ends the run.
   task automatic offer(input logic [31:0] pc, input bit ordy);
      bit a;
      int n;
      a = 1'b0;
      n = 0;
      while (!a && n < 20) begin
         step(1'b1, pc, 1'b0, ordy, a);
         n++;
      end
      check("offer_accepted", 64'(a), 64'd1);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("out_valid", 64'(out_valid), 64'(exp_ov));
         check("in_ready", 64'(in_ready), 64'(m_cnt != DEPTH));
         check("count", 64'(count), 64'(m_cnt));
         if (!out_valid) begin
            check("idle_ir", 64'(out_ir), 64'(NOP));
            check("idle_pc", 64'(out_pc), 64'd0);
         end else if (sb.size() == 0) begin
            check("head_without_entry", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            check("head_pc", 64'(out_pc), 64'(sb[0].pc));
            check("head_ir", 64'(out_ir), 64'(sb[0].ir));
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      bit a;
      int guard;
      total = 0; bad = 0;
      mon_en = 1'b0;
      m_cnt = 0; m_next = 0; exp_ov = 1'b0;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_ir = '0;

      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_ir", 64'(out_ir), 64'(NOP));
      check("rst_out_pc", 64'(out_pc), 64'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      mon_en = 1'b1;

      // Fill with the consumer stalled, then offer a fifth entry that must bounce.
      for (int i = 0; i < 4; i++) offer(32'(i * 4), 1'b0);
      step(1'b1, 32'h10, 1'b0, 1'b0, a);
      check("full_rejects", 64'(a), 64'd0);
      step(1'b1, 32'h10, 1'b0, 1'b0, a);
      check("full_count", 64'(m_cnt), 64'(DEPTH));

      // Drain from full while pushing, wrapping both pointers.
      for (int i = 4; i < 10; i++) offer(32'(i * 4), 1'b1);

      // Settle at two entries, then stream with simultaneous push and pop.
      guard = 0;
      while (m_next > 2 && guard < 20) begin idle(1'b1); guard++; end
      while (m_next < 2 && guard < 40) begin offer(32'h200 + 32'(guard * 4), 1'b0); guard++; end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b1, a);
         check("pushpop_accept", 64'(a), 64'd1);
      end
      idle(1'b0);
      check("pushpop_count", 64'(m_cnt), 64'd2);

      // Flush at three entries together with a push; then a fresh push heads the queue.
      offer(32'h3F0, 1'b0);
      step(1'b1, 32'h40, 1'b1, 1'b0, a);
      step(1'b1, 32'h80, 1'b0, 1'b0, a);
      check("post_flush_push", 64'(a), 64'd1);
      idle(1'b1);
      idle(1'b1);

      // Empty queue, entry offered with the consumer ready.
      step(1'b1, 32'h100, 1'b0, 1'b1, a);
      check("bypass_count_next", 64'(m_next), BYP ? 64'd0 : 64'd1);
      idle(1'b1);
      idle(1'b1);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 32'($urandom) & 32'hFFFF_FFFC,
              $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0, a);
      end

      // Asynchronous reset in the middle of traffic.
      for (int i = 0; i < 3; i++) offer(32'h500 + 32'(i * 4), 1'b0);
      #1;
      in_valid = 1'b0; flush = 1'b0; rst_n = 1'b0;
      sb.delete(); m_cnt = 0; m_next = 0; exp_ov = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_count", 64'(count), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_ir", 64'(out_ir), 64'(NOP));
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) offer(32'h600 + 32'(i * 4), $urandom_range(0, 1) == 1);

      for (int i = 0; i < DEPTH + 3; i++) idle(1'b1);
      @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
